ctrl_seq: RTL and testbench
===========================

// Module: ctrl_seq
// PURPOSE
//  Parametrised control unit for the bit-serial processor; successor to the 1-bit control unit.
//  Decodes 4-bit opcodes into a logic-unit op (luop) plus per-lane input/output enable masks
//  across DATA_W lanes. Adds the flow-control set: JMP, RTN, SKZ, NOP0/NOPF flags, and skip state.
//  Adds an instr_valid qualifier. Store and flow events are one-cycle strobes, not sticky levels.
// PARAMETERS
//  DATA_W  8  number of data lanes; width of data, ien, oen, sto
//  OP_W    4  opcode width; fixed at 4, any other value is a compile-time error
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       reset, asynchronous, active-high
//  instruction  in   4       opcode
//  instr_valid  in   1       opcode is decoded only when 1
//  data         in   DATA_W  operand for IEN/OEN mask loads
//  rr_zero      in   1       result register is all-zero; used by SKZ
//  luop         out  3       logic-unit operation, held until the next LU/STO opcode
//  lu_en        out  1       1-cycle strobe: LU op issued
//  ien          out  DATA_W  per-lane input enable mask
//  oen          out  DATA_W  per-lane output enable mask
//  sto          out  DATA_W  1-cycle per-lane store strobe
//  jmp          out  1       1-cycle strobe
//  rtn          out  1       1-cycle strobe
//  flag0        out  1       1-cycle strobe
//  flagf        out  1       1-cycle strobe
//  skip         out  1       next valid opcode will be discarded
// BEHAVIOUR
//  Reset state (all outputs): luop=000, lu_en=0, ien=0, oen=0, sto=0, jmp=0, rtn=0, flag0=0,
//   flagf=0, skip=0. Reset is async; mid-operation it also clears pending skip and any strobe.
//  Timing: all outputs registered. Opcode sampled at edge N -> effect visible after edge N.
//  Strobes default to 0 every cycle; high for exactly one cycle per accepted opcode.
//  instr_valid=0: no state change; strobes 0; skip retained.
//  instr_valid=1 and skip=1: opcode discarded, skip<=0, strobes 0, luop/ien/oen unchanged.
//  instr_valid=1 and skip=0, decode:
//   0 NOP0 -> flag0 strobe
//   1..7 LD, LDC, AND, ANDC, OR, ORC, XNOR -> luop<=opcode[2:0]; lu_en strobe
//   8 STO  -> luop<=001; sto<=oen (mask value before this edge)
//   9 STOC -> luop<=010; sto<=oen (mask value before this edge)
//   A IEN  -> ien<=data
//   B OEN  -> oen<=data
//   C JMP  -> jmp strobe
//   D RTN  -> rtn strobe; skip<=1
//   E SKZ  -> skip<=rr_zero
//   F NOPF -> flagf strobe
//  Back-to-back: OEN then STO on consecutive cycles -> STO uses the new oen.
//  sto=0 when oen=0; the strobe still occurs but with no lanes set. luop still updates.
//  SKZ/RTN skip applies to the next valid opcode only. Invalid cycles between do not consume it.
//   A skipped SKZ/RTN does not re-arm skip.
// STRUCTURE
//  Package ctrl_pkg: opcode localparams OP_NOP0..OP_NOPF; LUOP_* encodings (LD=001 .. XNOR=111).
//  Sub-module ctrl_decode: combinational opcode -> {luop, is_lu, is_sto, is_ien, is_oen,
//   is_jmp, is_rtn, is_skz, is_nop0, is_nopf}.
//  Top: skip flop, mask registers, strobe registers, async-reset always block.
// TESTING
//  1. Reset: assert rst asynchronously between edges -> all outputs 0 immediately; hold 2 cycles.
//  2. DATA_W=8. Issue OEN data=0xA5, then STO -> sto=0xA5 for one cycle, luop=001; next cycle sto=0x00.
//  3. SKZ with rr_zero=1, then LD -> skip=1 after SKZ; LD discarded (lu_en=0, luop unchanged); skip=0.
//     Repeat with rr_zero=0 -> LD executes, luop=001, lu_en=1.
//  4. RTN, instr_valid=0 for 3 cycles, then JMP -> rtn strobe; skip held through the idle cycles;
//     JMP discarded (jmp stays 0).
//  5. Opcodes 0..F each with instr_valid=1 -> each strobe and register update matches the decode table.
//     Repeat with instr_valid=0 -> no change.
//  6. Assert rst while skip=1 and sto active -> skip=0 and sto=0 asynchronously.
//     After release, the first LD executes normally.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Opcode map, logic-unit op encodings and decoded-opcode record for the bit-serial control unit.
package ctrl_pkg;

  localparam logic [3:0] OP_NOP0 = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_LDC  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_ANDC = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_ORC  = 4'h6;
  localparam logic [3:0] OP_XNOR = 4'h7;
  localparam logic [3:0] OP_STO  = 4'h8;
  localparam logic [3:0] OP_STOC = 4'h9;
  localparam logic [3:0] OP_IEN  = 4'hA;
  localparam logic [3:0] OP_OEN  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RTN  = 4'hD;
  localparam logic [3:0] OP_SKZ  = 4'hE;
  localparam logic [3:0] OP_NOPF = 4'hF;

  localparam logic [2:0] LUOP_NONE = 3'b000;
  localparam logic [2:0] LUOP_LD   = 3'b001;
  localparam logic [2:0] LUOP_LDC  = 3'b010;
  localparam logic [2:0] LUOP_AND  = 3'b011;
  localparam logic [2:0] LUOP_ANDC = 3'b100;
  localparam logic [2:0] LUOP_OR   = 3'b101;
  localparam logic [2:0] LUOP_ORC  = 3'b110;
  localparam logic [2:0] LUOP_XNOR = 3'b111;

  typedef struct packed {
    logic [2:0] luop;
    logic       is_lu;
    logic       is_sto;
    logic       is_ien;
    logic       is_oen;
    logic       is_jmp;
    logic       is_rtn;
    logic       is_skz;
    logic       is_nop0;
    logic       is_nopf;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: one-hot class flags plus the logic-unit op the opcode implies.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] op,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    unique case (op)
      OP_NOP0: dec.is_nop0 = 1'b1;
      OP_STO: begin
        dec.is_sto = 1'b1;
        dec.luop   = LUOP_LD;
      end
      OP_STOC: begin
        dec.is_sto = 1'b1;
        dec.luop   = LUOP_LDC;
      end
      OP_IEN:  dec.is_ien  = 1'b1;
      OP_OEN:  dec.is_oen  = 1'b1;
      OP_JMP:  dec.is_jmp  = 1'b1;
      OP_RTN:  dec.is_rtn  = 1'b1;
      OP_SKZ:  dec.is_skz  = 1'b1;
      OP_NOPF: dec.is_nopf = 1'b1;
      // 1..7 map straight onto the logic-unit encodings
      default: begin
        dec.is_lu = 1'b1;
        dec.luop  = op[2:0];
      end
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Bit-serial control unit: decodes valid opcodes into registered luop, lane masks and one-cycle strobes.
// All outputs registered (opcode at edge N visible after edge N); a pending skip discards the next valid opcode.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   instruction,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] data,
  input  logic              rr_zero,
  output logic [2:0]        luop,
  output logic              lu_en,
  output logic [DATA_W-1:0] ien,
  output logic [DATA_W-1:0] oen,
  output logic [DATA_W-1:0] sto,
  output logic              jmp,
  output logic              rtn,
  output logic              flag0,
  output logic              flagf,
  output logic              skip
);

  if (OP_W != 4) begin : g_op_w_check
    $error("ctrl_seq: OP_W must be 4");
  end

  dec_t dec;

  ctrl_decode u_decode (
    .op  (instruction[3:0]),
    .dec (dec)
  );

  logic [2:0]        luop_q,  luop_d;
  logic              lu_en_q, lu_en_d;
  logic [DATA_W-1:0] ien_q,   ien_d;
  logic [DATA_W-1:0] oen_q,   oen_d;
  logic [DATA_W-1:0] sto_q,   sto_d;
  logic              jmp_q,   jmp_d;
  logic              rtn_q,   rtn_d;
  logic              flag0_q, flag0_d;
  logic              flagf_q, flagf_d;
  logic              skip_q,  skip_d;

  always_comb begin
    luop_d  = luop_q;
    ien_d   = ien_q;
    oen_d   = oen_q;
    skip_d  = skip_q;
    lu_en_d = 1'b0;
    sto_d   = '0;
    jmp_d   = 1'b0;
    rtn_d   = 1'b0;
    flag0_d = 1'b0;
    flagf_d = 1'b0;

    if (instr_valid) begin
      if (skip_q) begin
        // discarded opcode only consumes the skip; a skipped RTN/SKZ cannot re-arm it
        skip_d = 1'b0;
      end else begin
        if (dec.is_lu) begin
          luop_d  = dec.luop;
          lu_en_d = 1'b1;
        end
        if (dec.is_sto) begin
          luop_d = dec.luop;
          sto_d  = oen_q;
        end
        if (dec.is_ien) ien_d = data;
        if (dec.is_oen) oen_d = data;
        jmp_d   = dec.is_jmp;
        rtn_d   = dec.is_rtn;
        flag0_d = dec.is_nop0;
        flagf_d = dec.is_nopf;
        if (dec.is_rtn) skip_d = 1'b1;
        if (dec.is_skz) skip_d = rr_zero;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      luop_q  <= LUOP_NONE;
      lu_en_q <= 1'b0;
      ien_q   <= '0;
      oen_q   <= '0;
      sto_q   <= '0;
      jmp_q   <= 1'b0;
      rtn_q   <= 1'b0;
      flag0_q <= 1'b0;
      flagf_q <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      luop_q  <= luop_d;
      lu_en_q <= lu_en_d;
      ien_q   <= ien_d;
      oen_q   <= oen_d;
      sto_q   <= sto_d;
      jmp_q   <= jmp_d;
      rtn_q   <= rtn_d;
      flag0_q <= flag0_d;
      flagf_q <= flagf_d;
      skip_q  <= skip_d;
    end
  end

  assign luop  = luop_q;
  assign lu_en = lu_en_q;
  assign ien   = ien_q;
  assign oen   = oen_q;
  assign sto   = sto_q;
  assign jmp   = jmp_q;
  assign rtn   = rtn_q;
  assign flag0 = flag0_q;
  assign flagf = flagf_q;
  assign skip  = skip_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: hand-computed output vectors checked 1 time unit after each rising edge.
module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] instruction = 4'h0;
  logic       instr_valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       rr_zero = 1'b0;
  logic [2:0] luop;
  logic       lu_en;
  logic [7:0] ien, oen, sto;
  logic       jmp, rtn, flag0, flagf, skip;

  int total = 0;
  int bad   = 0;

  ctrl_seq #(.DATA_W(8), .OP_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .data        (data),
    .rr_zero     (rr_zero),
    .luop        (luop),
    .lu_en       (lu_en),
    .ien         (ien),
    .oen         (oen),
    .sto         (sto),
    .jmp         (jmp),
    .rtn         (rtn),
    .flag0       (flag0),
    .flagf       (flagf),
    .skip        (skip)
  );

  always #5 clk = ~clk;

  // {luop, lu_en, sto, ien, oen, jmp, rtn, flag0, flagf, skip}
  function automatic logic [32:0] pk(input logic [2:0] l, input logic le, input logic [7:0] s,
                                     input logic [7:0] i, input logic [7:0] o,
                                     input logic [3:0] fl, input logic sk);
    return {l, le, s, i, o, fl, sk};
  endfunction

  function automatic logic [32:0] obs();
    return {luop, lu_en, sto, ien, oen, jmp, rtn, flag0, flagf, skip};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // drive an opcode, clock it in, and land 1 unit after the edge
  task automatic issue(input logic [3:0] op, input logic vld, input logic [7:0] d, input logic rz);
    instruction = op;
    instr_valid = vld;
    data        = d;
    rr_zero     = rz;
    @(posedge clk);
    #1;
  endtask

  logic [32:0] exp_tab [16];

  initial begin
    // 1: async reset between edges
    #3 rst = 1'b1;
    #1 chk("rst_async", obs(), pk(3'd0, 0, 8'h00, 8'h00, 8'h00, 4'b0000, 0));
    repeat (2) @(posedge clk);
    #1 chk("rst_hold", obs(), pk(3'd0, 0, 8'h00, 8'h00, 8'h00, 4'b0000, 0));
    rst = 1'b0;

    // 2: OEN then STO back-to-back
    issue(4'hB, 1, 8'hA5, 0);
    chk("oen_load", obs(), pk(3'd0, 0, 8'h00, 8'h00, 8'hA5, 4'b0000, 0));
    issue(4'h8, 1, 8'h00, 0);
    chk("sto_strobe", obs(), pk(3'd1, 0, 8'hA5, 8'h00, 8'hA5, 4'b0000, 0));
    issue(4'h0, 0, 8'h00, 0);
    chk("sto_clear", obs(), pk(3'd1, 0, 8'h00, 8'h00, 8'hA5, 4'b0000, 0));

    // 3: SKZ taken / not taken
    issue(4'h3, 1, 8'h00, 0);
    chk("and_op", obs(), pk(3'd3, 1, 8'h00, 8'h00, 8'hA5, 4'b0000, 0));
    issue(4'hE, 1, 8'h00, 1);
    chk("skz_arm", obs(), pk(3'd3, 0, 8'h00, 8'h00, 8'hA5, 4'b0000, 1));
    issue(4'h1, 1, 8'h00, 1);
    chk("skz_discard_ld", obs(), pk(3'd3, 0, 8'h00, 8'h00, 8'hA5, 4'b0000, 0));
    issue(4'hE, 1, 8'h00, 0);
    chk("skz_noarm", obs(), pk(3'd3, 0, 8'h00, 8'h00, 8'hA5, 4'b0000, 0));
    issue(4'h1, 1, 8'h00, 0);
    chk("ld_exec", obs(), pk(3'd1, 1, 8'h00, 8'h00, 8'hA5, 4'b0000, 0));

    // 4: RTN, idle cycles keep skip, JMP discarded
    issue(4'hD, 1, 8'h00, 0);
    chk("rtn_strobe", obs(), pk(3'd1, 0, 8'h00, 8'h00, 8'hA5, 4'b0100, 1));
    for (int k = 0; k < 3; k++) begin
      issue(4'hC, 0, 8'h00, 0);
      chk($sformatf("rtn_idle%0d", k), obs(), pk(3'd1, 0, 8'h00, 8'h00, 8'hA5, 4'b0000, 1));
    end
    issue(4'hC, 1, 8'h00, 0);
    chk("jmp_discard", obs(), pk(3'd1, 0, 8'h00, 8'h00, 8'hA5, 4'b0000, 0));
    issue(4'hC, 1, 8'h00, 0);
    chk("jmp_exec", obs(), pk(3'd1, 0, 8'h00, 8'h00, 8'hA5, 4'b1000, 0));

    // 5: full sweep, data = 0x30+op; RTN at D makes SKZ at E a discard
    exp_tab[0]  = pk(3'd1, 0, 8'h00, 8'h00, 8'hA5, 4'b0010, 0);
    exp_tab[1]  = pk(3'd1, 1, 8'h00, 8'h00, 8'hA5, 4'b0000, 0);
    exp_tab[2]  = pk(3'd2, 1, 8'h00, 8'h00, 8'hA5, 4'b0000, 0);
    exp_tab[3]  = pk(3'd3, 1, 8'h00, 8'h00, 8'hA5, 4'b0000, 0);
    exp_tab[4]  = pk(3'd4, 1, 8'h00, 8'h00, 8'hA5, 4'b0000, 0);
    exp_tab[5]  = pk(3'd5, 1, 8'h00, 8'h00, 8'hA5, 4'b0000, 0);
    exp_tab[6]  = pk(3'd6, 1, 8'h00, 8'h00, 8'hA5, 4'b0000, 0);
    exp_tab[7]  = pk(3'd7, 1, 8'h00, 8'h00, 8'hA5, 4'b0000, 0);
    exp_tab[8]  = pk(3'd1, 0, 8'hA5, 8'h00, 8'hA5, 4'b0000, 0);
    exp_tab[9]  = pk(3'd2, 0, 8'hA5, 8'h00, 8'hA5, 4'b0000, 0);
    exp_tab[10] = pk(3'd2, 0, 8'h00, 8'h3A, 8'hA5, 4'b0000, 0);
    exp_tab[11] = pk(3'd2, 0, 8'h00, 8'h3A, 8'h3B, 4'b0000, 0);
    exp_tab[12] = pk(3'd2, 0, 8'h00, 8'h3A, 8'h3B, 4'b1000, 0);
    exp_tab[13] = pk(3'd2, 0, 8'h00, 8'h3A, 8'h3B, 4'b0100, 1);
    exp_tab[14] = pk(3'd2, 0, 8'h00, 8'h3A, 8'h3B, 4'b0000, 0);
    exp_tab[15] = pk(3'd2, 0, 8'h00, 8'h3A, 8'h3B, 4'b0001, 0);
    for (int i = 0; i < 16; i++) begin
      issue(i[3:0], 1, 8'h30 + i[7:0], 1);
      chk($sformatf("sweep_op%0h", i), obs(), exp_tab[i]);
    end
    for (int i = 0; i < 16; i++) begin
      issue(i[3:0], 0, 8'hC0 + i[7:0], 1);
      chk($sformatf("idle_op%0h", i), obs(), pk(3'd2, 0, 8'h00, 8'h3A, 8'h3B, 4'b0000, 0));
    end

    // 6: reset clears pending skip, and separately a live sto strobe
    issue(4'hD, 1, 8'h00, 0);
    chk("rtn_pre_rst", obs(), pk(3'd2, 0, 8'h00, 8'h3A, 8'h3B, 4'b0100, 1));
    #2 rst = 1'b1;
    #1 chk("rst_skip", obs(), pk(3'd0, 0, 8'h00, 8'h00, 8'h00, 4'b0000, 0));
    @(posedge clk);
    #1 rst = 1'b0;
    issue(4'hB, 1, 8'h5A, 0);
    issue(4'h9, 1, 8'h00, 0);
    chk("stoc_pre_rst", obs(), pk(3'd2, 0, 8'h5A, 8'h00, 8'h5A, 4'b0000, 0));
    #2 rst = 1'b1;
    #1 chk("rst_sto", obs(), pk(3'd0, 0, 8'h00, 8'h00, 8'h00, 4'b0000, 0));
    @(posedge clk);
    #1 rst = 1'b0;
    issue(4'h1, 1, 8'h00, 0);
    chk("ld_after_rst", obs(), pk(3'd1, 1, 8'h00, 8'h00, 8'h00, 4'b0000, 0));
    issue(4'h8, 1, 8'h00, 0);
    chk("sto_zero_mask", obs(), pk(3'd1, 0, 8'h00, 8'h00, 8'h00, 4'b0000, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
